// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 encoding and byte-lane helpers shared by the dmem_lsu files
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } ls_f3_e;

    // Byte lanes touched by an access of the given size at the given offset
    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << off;
            F3_H, F3_HU: be = 4'b0011 << off;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Select the addressed byte/half from a RAM word and sign/zero extend it
    function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0, h};
            F3_W:    r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_bank.sv
// rtl/dmem_lsu_bank.sv - DEPTH x DW single-port RAM, per-lane write enable, read-first registered output
module dmem_lsu_bank #(
    parameter int DEPTH = 4096,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    localparam int LW = DW / 4;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Read-first access; output register only updates when the port is enabled
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][i*LW +: LW] <= i_wdata[i*LW +: LW];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - RV32I load/store unit over on-chip SRAM; optional per-byte parity with DMEM_PARITY_EN
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_PARITY_EN
    ,
    input  logic [3:0]        dbg_flip_par
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef DMEM_PARITY_EN
    localparam int DW = 36;
`else
    localparam int DW = 32;
`endif

    logic             w_accept;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_range_err;
    logic             w_misal;
    logic             w_illegal;
    logic             w_fault;
    logic [3:0]       w_bank_we;
    logic [31:0]      w_wdata32;
    logic [DW-1:0]    w_bank_wdata;
    logic [DW-1:0]    w_bank_rdata;
    logic [31:0]      w_word;
    logic [31:0]      w_ld_data;
    logic             w_par_err;

    logic             r_valid;
    logic             r_err;
    logic             r_load;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;

    assign req_ready   = !r_valid || rsp_ready;
    assign w_accept    = req_valid && req_ready;
    assign w_off       = req_addr[1:0];
    assign w_idx       = req_addr[IDX_W+1:2];
    assign w_range_err = |req_addr[ADDR_W-1:IDX_W+2];

    // Size/alignment and funct3 legality decode; BU/HU exist only as loads
    always_comb begin
        w_misal   = 1'b0;
        w_illegal = 1'b0;
        case (req_funct3)
            F3_B:    w_misal = 1'b0;
            F3_H:    w_misal = req_addr[0];
            F3_W:    w_misal = |req_addr[1:0];
            F3_BU:   w_illegal = req_we;
            F3_HU: begin
                w_illegal = req_we;
                w_misal   = req_addr[0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_fault   = w_range_err || w_misal || w_illegal;
    assign w_bank_we = (w_accept && req_we && !w_fault) ? be_gen(req_funct3, w_off) : 4'b0000;

    // Replicate store data across lanes so the byte enables alone pick the target bytes
    always_comb begin
        w_wdata32 = req_wdata;
        case (req_funct3)
            F3_B:    w_wdata32 = {4{req_wdata[7:0]}};
            F3_H:    w_wdata32 = {2{req_wdata[15:0]}};
            default: w_wdata32 = req_wdata;
        endcase
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] w_lane_bad;

    // Append even parity per byte; the debug hook corrupts it on the store being written
    always_comb begin
        w_bank_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            w_bank_wdata[i*9 +: 9] = {(^w_wdata32[i*8 +: 8]) ^ dbg_flip_par[i], w_wdata32[i*8 +: 8]};
        end
    end

    // Strip parity from the read word and flag lanes whose 9 bits have odd parity
    always_comb begin
        w_word     = '0;
        w_lane_bad = '0;
        for (int i = 0; i < 4; i++) begin
            w_word[i*8 +: 8] = w_bank_rdata[i*9 +: 8];
            w_lane_bad[i]    = ^w_bank_rdata[i*9 +: 9];
        end
    end

    assign w_par_err = r_load && !r_err && (|(w_lane_bad & be_gen(r_f3, r_off)));
`else
    assign w_bank_wdata = w_wdata32;
    assign w_word       = w_bank_rdata;
    assign w_par_err    = 1'b0;
`endif

    dmem_lsu_bank #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (IDX_W)
    ) u_bank (
        .i_clk   (clk),
        .i_en    (w_accept),
        .i_we    (w_bank_we),
        .i_addr  (w_idx),
        .i_wdata (w_bank_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Response register: capture access attributes on accept, clear when consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_err   <= w_fault;
            r_load  <= !req_we;
            r_f3    <= req_funct3;
            r_off   <= w_off;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Extraction works off held state, so rdata stays stable while stalled
    assign w_ld_data = ld_extract(w_word, r_f3, r_off);
    assign rsp_valid = r_valid;
    assign rsp_err   = r_valid && (r_err || w_par_err);
    assign rsp_rdata = (r_valid && r_load && !r_err && !w_par_err) ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu against a byte-array reference model
`timescale 1ns/1ps
module tb_dmem_lsu;

    localparam int DEPTH  = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  dbg_flip_par;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [NBYTES];
    bit         bad_m [NBYTES];

    always #5 clk = ~clk;

    dmem_lsu #(
        .DEPTH  (DEPTH),
        .ADDR_W (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
`ifdef DMEM_PARITY_EN
        .dbg_flip_par (dbg_flip_par),
`endif
        .rsp_err      (rsp_err)
    );

    // Reference: byte-addressed memory, access size from funct3, little-endian assembly
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic e, output logic [31:0] d);
        int  sz;
        bit  sgn;
        bit  ill;
        bit  anybad;
        sz = 1; sgn = 0; ill = 0; anybad = 0;
        case (f3)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: begin sz = 4; sgn = 0; end
            3'd4: begin sz = 1; sgn = 0; ill = we; end
            3'd5: begin sz = 2; sgn = 0; ill = we; end
            default: ill = 1;
        endcase
        e = ill || (a % sz != 0) || (a >= NBYTES);
        d = 32'h0;
        if (!e) begin
            if (we) begin
                for (int k = 0; k < sz; k++) begin
                    mem_m[int'(a) + k] = 8'(wd >> (8 * k));
                    bad_m[int'(a) + k] = dbg_flip_par[(int'(a) + k) % 4];
                end
            end else begin
                for (int k = 0; k < sz; k++) begin
                    d = d | (32'(mem_m[int'(a) + k]) << (8 * k));
                    anybad = anybad | bad_m[int'(a) + k];
                end
                if (sgn && sz < 4 && d[8*sz-1]) d = d | (32'hFFFF_FFFF << (8 * sz));
                if (anybad) begin
                    e = 1;
                    d = 32'h0;
                end
            end
        end
    endtask

    task automatic rand_req(input bit loads_only, output logic we, output logic [2:0] f3,
                            output logic [31:0] a, output logic [31:0] wd);
        logic [2:0] legal [5];
        int         sz;
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
        wd = $urandom;
        if (loads_only) begin
            we = 1'b0;
            f3 = legal[$urandom_range(0, 4)];
            sz = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
            a  = 32'($urandom_range(0, NBYTES - 1));
            a  = a - (a % sz);
        end else begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, NBYTES + 15));
        end
    endtask

    // One request with rsp_ready held high; returns the response seen one cycle after accept
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic v, output logic e, output logic [31:0] d);
        int          w;
        logic        me;
        logic [31:0] md;
        w = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = 1'b1;
        while (!req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) begin
            errors++;
            $display("FAIL xact_ready_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        v = rsp_valid; e = rsp_err; d = rsp_rdata;
        model(we, f3, a, wd, me, md);
        @(posedge clk); #1;
    endtask

    // Cycle-level stream: DUT handshake must follow the ready rule and deliver each response once
    task automatic run_stream(input int n, input bit rnd_stall, input bit loads_only);
        int          idx;
        int          cyc;
        int          got;
        bit          exp_v;
        logic        exp_e;
        logic [31:0] exp_d;
        logic        c_we;
        logic [2:0]  c_f3;
        logic [31:0] c_a;
        logic [31:0] c_wd;
        bit          acc;
        bit          cons;
        idx = 0; cyc = 0; got = 0; exp_v = 0; exp_e = 0; exp_d = 32'h0;
        rand_req(loads_only, c_we, c_f3, c_a, c_wd);
        while ((idx < n || exp_v) && cyc < 20 * n + 50) begin
            req_valid = (idx < n); req_we = c_we; req_funct3 = c_f3; req_addr = c_a; req_wdata = c_wd;
            rsp_ready = rnd_stall ? ($urandom_range(0, 3) != 0) : !(cyc >= 1 && cyc <= 3);
            @(negedge clk);
            checks++;
            if (req_ready !== (!exp_v || rsp_ready)) begin
                errors++;
                $display("FAIL stream_req_ready cyc=%0d: got %b required %b", cyc, req_ready, !exp_v || rsp_ready);
            end
            checks++;
            if (rsp_valid !== exp_v) begin
                errors++;
                $display("FAIL stream_rsp_valid cyc=%0d: got %b required %b", cyc, rsp_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rsp_err !== exp_e || rsp_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL stream_rsp cyc=%0d: got err=%b data=%h required err=%b data=%h",
                             cyc, rsp_err, rsp_rdata, exp_e, exp_d);
                end
            end
            acc  = req_valid && req_ready;
            cons = rsp_valid && rsp_ready;
            @(posedge clk); #1;
            if (cons) begin
                got++;
                exp_v = 0;
            end
            if (acc) begin
                model(c_we, c_f3, c_a, c_wd, exp_e, exp_d);
                exp_v = 1;
                idx++;
                rand_req(loads_only, c_we, c_f3, c_a, c_wd);
            end
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        checks++;
        if (idx != n || got != n) begin
            errors++;
            $display("FAIL stream_count: accepted %0d responses %0d required %0d", idx, got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0;
        req_wdata = 32'h0; rsp_ready = 1'b1; dbg_flip_par = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b err=%b data=%h ready=%b required 0 0 0 1",
                     rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic prefill();
        logic v, e;
        logic [31:0] d;
        for (int w = 0; w < DEPTH; w++) xact(1'b1, 3'd2, 32'(4 * w), $urandom, v, e, d);
    endtask

    task automatic test_directed();
        logic        v, e;
        logic [31:0] d;
        logic [2:0]  f_f3 [4];
        logic [31:0] f_a  [4];
        f_f3[0] = 3'd2; f_a[0] = 32'h12;
        f_f3[1] = 3'd1; f_a[1] = 32'h11;
        f_f3[2] = 3'd3; f_a[2] = 32'h10;
        f_f3[3] = 3'd2; f_a[3] = 32'(4 * DEPTH);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, v, e, d);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL sw_rsp: got v=%b err=%b data=%h required 1 0 0", v, e, d);
        end
        xact(1'b0, 3'd2, 32'h10, 32'h0, v, e, d);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_rsp: got v=%b err=%b data=%h required 1 0 deadbeef", v, e, d);
        end
        xact(1'b1, 3'd0, 32'h13, 32'h0000_0080, v, e, d);
        xact(1'b0, 3'd0, 32'h13, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb_sext: got err=%b data=%h required 0 ffffff80", e, d);
        end
        xact(1'b0, 3'd4, 32'h13, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h00000080) begin
            errors++; $display("FAIL lbu_zext: got err=%b data=%h required 0 00000080", e, d);
        end
        xact(1'b0, 3'd1, 32'h12, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'hFFFF80AD) begin
            errors++; $display("FAIL lh_sext: got err=%b data=%h required 0 ffff80ad", e, d);
        end
        for (int i = 0; i < 4; i++) begin
            xact(i == 1, f_f3[i], f_a[i], 32'h1234_5678, v, e, d);
            checks++;
            if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
                errors++; $display("FAIL fault_%0d: got v=%b err=%b data=%h required 1 1 0", i, v, e, d);
            end
        end
        xact(1'b0, 3'd2, 32'h10, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h80ADBEEF) begin
            errors++; $display("FAIL word_unchanged: got err=%b data=%h required 0 80adbeef", e, d);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(6, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        run_stream(400, 1'b1, 1'b0);
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        logic        v, e;
        logic [31:0] d;
        dbg_flip_par = 4'b0100;
        xact(1'b1, 3'd2, 32'h20, 32'h11223344, v, e, d);
        dbg_flip_par = 4'b0000;
        xact(1'b0, 3'd4, 32'h22, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL par_bad_lane: got err=%b data=%h required 1 0", e, d);
        end
        xact(1'b0, 3'd4, 32'h20, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h44) begin
            errors++; $display("FAIL par_good_lane: got err=%b data=%h required 0 44", e, d);
        end
        xact(1'b1, 3'd0, 32'h22, 32'h55, v, e, d);
        xact(1'b0, 3'd2, 32'h20, 32'h0, v, e, d);
        checks++;
        if (e !== 1'b0 || d !== 32'h11553344) begin
            errors++; $display("FAIL par_rewrite: got err=%b data=%h required 0 11553344", e, d);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic        v, e;
        logic [31:0] d;
        xact(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, v, e, d);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h30; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL pre_reset_rsp: got v=%b data=%h required 1 cafef00d", rsp_valid, rsp_rdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL async_reset: got v=%b err=%b data=%h required 0 0 0", rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        xact(1'b0, 3'd2, 32'h30, 32'h0, v, e, d);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'hCAFEF00D) begin
            errors++; $display("FAIL store_survives_reset: got v=%b err=%b data=%h required 1 0 cafef00d", v, e, d);
        end
    endtask

    initial begin
        test_reset();
        prefill();
        test_directed();
        test_back_to_back();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
